// File: rtl/insn_prefetch_queue_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : insn_prefetch_queue_pkg                                           |
// | Brief  : Shared constants and queue entry type for the prefetch queue.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package insn_prefetch_queue_pkg;

  localparam logic [31:0] NOP_INSN          = 32'h0000_0000;
  localparam logic [1:0]  ACCESS_WORD       = 2'b00;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8002_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } pfq_entry_t;

endpackage

`default_nettype wire

// File: rtl/insn_prefetch_queue_if.sv
// +----------------------------------------------------------------------------+
// | Module : insn_prefetch_queue_if                                            |
// | Brief  : IMEM request/response and decode/execute signals of the queue.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface insn_prefetch_queue_if;

  logic [31:0] imem_address;
  logic        imem_enable;
  logic        imem_rw;
  logic [1:0]  imem_access_size;
  logic        imem_busy;
  logic [31:0] imem_data_out;
  logic        stall;
  logic        do_branch;
  logic [31:0] pc_effective;
  logic [31:0] pc_out;
  logic [31:0] insn_out;
  logic        insn_valid;

  modport master (
    output imem_address, imem_enable, imem_rw, imem_access_size,
    output pc_out, insn_out, insn_valid,
    input  imem_busy, imem_data_out, stall, do_branch, pc_effective
  );

  modport slave (
    input  imem_address, imem_enable, imem_rw, imem_access_size,
    input  pc_out, insn_out, insn_valid,
    output imem_busy, imem_data_out, stall, do_branch, pc_effective
  );

endinterface

`default_nettype wire

// File: rtl/insn_prefetch_queue_fifo.sv
// +----------------------------------------------------------------------------+
// | Module : pfq_fifo                                                          |
// | Brief  : DEPTH x {pc, insn} synchronous FIFO with push/pop/flush.          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pfq_fifo
  import insn_prefetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire pfq_entry_t       push_data,
  input  wire logic             pop,
  input  wire logic             flush,
  output pfq_entry_t            head,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  pfq_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/insn_prefetch_queue.sv
// +----------------------------------------------------------------------------+
// | Module : insn_prefetch_queue                                               |
// | Brief  : Sequential IMEM prefetcher feeding decode, flushed on redirect.   |
// |          Define PFQ_BYPASS_EN to forward a response straight to the head   |
// |          outputs when the queue is empty.                                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module insn_prefetch_queue
  import insn_prefetch_queue_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          DEPTH     = 4
) (
  input wire logic              clock,
  input wire logic              reset,
  insn_prefetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      issued_pc_q, issued_pc_d;
  logic             inflight_q, inflight_d;
  logic             tag_q, tag_d;
  logic             epoch_q, epoch_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  pfq_entry_t       fifo_head;
  pfq_entry_t       resp_entry;
  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             accept;
  logic             resp_ok;
  logic             bypass;
  logic             head_valid;
  logic             pop;
  logic             fifo_push;
  logic             fifo_pop;

  // Requests in flight count against capacity so a response always has a slot.
  always_comb begin
    occupancy  = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight_q);
    issue      = !reset && !bus.do_branch && (occupancy < (CNT_W + 1)'(DEPTH));
    accept     = issue && !bus.imem_busy;
    resp_ok    = inflight_q && (tag_q == epoch_q) && !bus.do_branch;
    resp_entry = '{pc: issued_pc_q, insn: bus.imem_data_out};
  end

`ifdef PFQ_BYPASS_EN
  assign bypass = fifo_empty && resp_ok;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    head_valid     = !fifo_empty || bypass;
    bus.insn_valid = head_valid;
    bus.pc_out     = 32'h0;
    bus.insn_out   = NOP_INSN;
    if (!fifo_empty) begin
      bus.pc_out   = fifo_head.pc;
      bus.insn_out = fifo_head.insn;
    end else if (bypass) begin
      bus.pc_out   = resp_entry.pc;
      bus.insn_out = resp_entry.insn;
    end
    pop       = head_valid && !bus.stall && !bus.do_branch;
    fifo_pop  = pop && !fifo_empty;
    // A bypassed response consumed by decode this cycle never enters the queue.
    fifo_push = resp_ok && !(bypass && pop) && !fifo_full;
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = accept;
    tag_d       = tag_q;
    epoch_d     = epoch_q;
    if (bus.do_branch) begin
      fetch_pc_d = bus.pc_effective & ~32'h3;
      epoch_d    = ~epoch_q;
    end else if (accept) begin
      fetch_pc_d  = fetch_pc_q + 32'd4;
      issued_pc_d = fetch_pc_q;
      tag_d       = epoch_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q  <= BASE_ADDR;
      issued_pc_q <= 32'h0;
      inflight_q  <= 1'b0;
      tag_q       <= 1'b0;
      epoch_q     <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      epoch_q     <= epoch_d;
    end
  end

  assign bus.imem_address     = fetch_pc_q;
  assign bus.imem_enable      = issue;
  assign bus.imem_rw          = 1'b1;
  assign bus.imem_access_size = ACCESS_WORD;

  pfq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (resp_entry),
    .pop       (fifo_pop),
    .flush     (bus.do_branch),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_insn_prefetch_queue.sv
// +----------------------------------------------------------------------------+
// | Module : tb_insn_prefetch_queue                                            |
// | Brief  : Directed bench with a scoreboard of expected decode pops.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_insn_prefetch_queue;
  import insn_prefetch_queue_pkg::*;

`ifdef PFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  insn_prefetch_queue_if bus ();

  insn_prefetch_queue #(
    .BASE_ADDR (32'h8002_0000),
    .DEPTH     (4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int pop_cnt     = 0;
  int acc_cnt     = 0;
  int base;
  pfq_entry_t sb[$];

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // IMEM model: data for an accepted request appears the following cycle.
  always @(posedge clk) begin
    if (bus.imem_enable && !bus.imem_busy) begin
      bus.imem_data_out <= insn_of(bus.imem_address);
      acc_cnt           <= acc_cnt + 1;
    end else begin
      bus.imem_data_out <= 32'hDEAD_BEEF;
    end
  end

  // Monitor: every decode pop must match the scoreboard head.
  initial begin
    pfq_entry_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.insn_valid && !bus.stall && !bus.do_branch) begin
        pop_cnt++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL pop_unexpected: got pc=%h insn=%h, expected no pop", bus.pc_out, bus.insn_out);
        end else begin
          e = sb.pop_front();
          if (bus.pc_out !== e.pc || bus.insn_out !== e.insn) begin
            miscompares++;
            $display("FAIL pop_entry: got pc=%h insn=%h, expected pc=%h insn=%h",
                     bus.pc_out, bus.insn_out, e.pc, e.insn);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      sb.push_back('{pc: a, insn: insn_of(a)});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // Leaves the bench at posedge+1 of the first cycle out of reset (cycle c0).
  task automatic do_reset();
    rst              = 1'b1;
    bus.stall        = 1'b0;
    bus.imem_busy    = 1'b0;
    bus.do_branch    = 1'b0;
    bus.pc_effective = 32'h0;
    sb.delete();
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    bus.stall        = 1'b0;
    bus.imem_busy    = 1'b0;
    bus.do_branch    = 1'b0;
    bus.pc_effective = 32'h0;
    rst              = 1'b1;
    repeat (2) to_neg();
    chk1("rst_valid",   bus.insn_valid, 1'b0);
    chk ("rst_pc",      bus.pc_out, 32'h0);
    chk ("rst_insn",    bus.insn_out, 32'h0);
    chk1("rst_enable",  bus.imem_enable, 1'b0);
    chk1("rst_rw",      bus.imem_rw, 1'b1);
    chk ("rst_size",    32'(bus.imem_access_size), 32'h0);
    chk ("rst_addr",    bus.imem_address, 32'h8002_0000);

    // Back-to-back sequential fetch from BASE_ADDR.
    do_reset();
    expect_seq(32'h8002_0000, 16);
    base = pop_cnt;
    to_neg();
    chk1("t1_en_c0", bus.imem_enable, 1'b1);
    chk ("t1_addr_c0", bus.imem_address, 32'h8002_0000);
    chk1("t1_valid_c0", bus.insn_valid, 1'b0);
    step(); to_neg();
    chk ("t1_addr_c1", bus.imem_address, 32'h8002_0004);
    chk1("t1_valid_c1", bus.insn_valid, BYP);
    step(); to_neg();
    chk ("t1_addr_c2", bus.imem_address, 32'h8002_0008);
    chk1("t1_valid_c2", bus.insn_valid, 1'b1);
    repeat (5) begin step(); to_neg(); end
    step();
    chk ("t1_pops", 32'(pop_cnt - base), BYP ? 32'd7 : 32'd6);

    // Stall from reset: queue fills to DEPTH, fetch stops, head stable.
    do_reset();
    bus.stall = 1'b1;
    expect_seq(32'h8002_0000, 8);
    base = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      to_neg();
      if (i >= 2) chk("t2_head_pc", bus.pc_out, 32'h8002_0000);
      if (i >= 4) chk1("t2_en_off", bus.imem_enable, 1'b0);
      step();
    end
    chk("t2_accepts", 32'(acc_cnt - base), 32'd4);
    bus.stall = 1'b0;
    base = pop_cnt;
    repeat (6) begin to_neg(); step(); end
    chk("t2_pops", 32'(pop_cnt - base), 32'd6);

    // Redirect with three queued entries and one response in flight.
    do_reset();
    bus.stall = 1'b1;
    expect_seq(32'h8002_0000, 4);
    repeat (4) begin to_neg(); step(); end
    bus.do_branch    = 1'b1;
    bus.pc_effective = 32'h8002_0103;
    bus.stall        = 1'b0;
    sb.delete();
    expect_seq(32'h8002_0100, 6);
    base = pop_cnt;
    to_neg();
    chk1("t3_en_branch", bus.imem_enable, 1'b0);
    chk1("t3_valid_branch", bus.insn_valid, 1'b1);
    step();
    bus.do_branch = 1'b0;
    to_neg();
    chk1("t3_en_redir", bus.imem_enable, 1'b1);
    chk ("t3_addr_redir", bus.imem_address, 32'h8002_0100);
    chk1("t3_valid_empty", bus.insn_valid, 1'b0);
    step(); to_neg();
    chk1("t3_valid_n2", bus.insn_valid, BYP);
    step(); to_neg();
    chk1("t3_valid_n3", bus.insn_valid, 1'b1);
    chk ("t3_pc_n3", bus.pc_out, BYP ? 32'h8002_0104 : 32'h8002_0100);
    repeat (2) begin step(); to_neg(); end
    step();
    chk("t3_pops", 32'(pop_cnt - base), BYP ? 32'd4 : 32'd3);

    // IMEM busy for three cycles: request held, single accept.
    do_reset();
    bus.imem_busy = 1'b1;
    expect_seq(32'h8002_0000, 8);
    base = acc_cnt;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk1("t4_en_held", bus.imem_enable, 1'b1);
      chk ("t4_addr_held", bus.imem_address, 32'h8002_0000);
      step();
    end
    bus.imem_busy = 1'b0;
    to_neg();
    chk("t4_addr_release", bus.imem_address, 32'h8002_0000);
    step(); to_neg();
    chk("t4_addr_next", bus.imem_address, 32'h8002_0004);
    chk("t4_accepts", 32'(acc_cnt - base), 32'd1);
    base = pop_cnt;
    repeat (4) begin step(); to_neg(); end
    step();
    chk("t4_pops", 32'(pop_cnt - base), BYP ? 32'd4 : 32'd4);

    // Address wrap past FFFFFFFC, then asynchronous reset mid-stream.
    do_reset();
    expect_seq(32'h8002_0000, 4);
    to_neg(); step(); to_neg(); step();
    bus.do_branch    = 1'b1;
    bus.pc_effective = 32'hFFFF_FFFC;
    sb.delete();
    expect_seq(32'hFFFF_FFFC, 8);
    to_neg(); step();
    bus.do_branch = 1'b0;
    to_neg();
    chk("t5_addr_top", bus.imem_address, 32'hFFFF_FFFC);
    step(); to_neg();
    chk("t5_addr_wrap", bus.imem_address, 32'h0000_0000);
    repeat (2) begin step(); to_neg(); end
    step();
    chk1("t5_valid_before", bus.insn_valid, 1'b1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk1("t5_valid_async", bus.insn_valid, 1'b0);
    chk1("t5_en_async", bus.imem_enable, 1'b0);
    chk ("t5_pc_async", bus.pc_out, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_seq(32'h8002_0000, 8);
    to_neg();
    chk("t5_addr_restart", bus.imem_address, 32'h8002_0000);
    repeat (4) begin step(); to_neg(); end

    // Single response into an empty queue: bypass latency.
    do_reset();
    to_neg(); step();
    bus.do_branch    = 1'b1;
    bus.pc_effective = 32'h8002_0008;
    expect_seq(32'h8002_0008, 1);
    to_neg(); step();
    bus.do_branch = 1'b0;
    to_neg();
    chk ("t6_addr", bus.imem_address, 32'h8002_0008);
    chk1("t6_valid_issue", bus.insn_valid, 1'b0);
    step();
    bus.imem_busy = 1'b1;
    to_neg();
    chk1("t6_valid_resp", bus.insn_valid, BYP);
    step(); to_neg();
    chk1("t6_valid_resp1", bus.insn_valid, !BYP);
    step(); to_neg();
    chk1("t6_valid_after", bus.insn_valid, 1'b0);
    chk ("t6_pc_empty", bus.pc_out, 32'h0);
    chk ("t6_insn_empty", bus.insn_out, 32'h0);
    step();
    chk("t6_sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
